// File: rtl/tdc_record_rx.sv
// TDC record link receiver: 8N1 deserialiser plus byte-to-record assembly with a valid/ready holding register.
// Optional TDC_RECORD_RX_STATS_EN adds saturating rec_count/err_count outputs.
`timescale 1ns/1ps
module tdc_record_rx #(
  parameter int CLK_PER_BIT      = 12,
  parameter int BYTES_PER_RECORD = 6,
  parameter int GAP_BITS         = 20
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rx,
  output logic [8*BYTES_PER_RECORD-1:0]   record,
  output logic                            record_valid,
  input  logic                            record_ready,
  output logic                            framing_err,
  output logic                            gap_err,
  output logic                            overrun
`ifdef TDC_RECORD_RX_STATS_EN
  ,
  output logic [15:0]                     rec_count,
  output logic [15:0]                     err_count
`endif
);

  localparam int RW        = 8 * BYTES_PER_RECORD;
  localparam int CW        = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int BCW       = (BYTES_PER_RECORD > 1) ? $clog2(BYTES_PER_RECORD) : 1;
  localparam int GAP_LIMIT = GAP_BITS * CLK_PER_BIT;
  localparam int GW        = $clog2(GAP_LIMIT + 1);

  localparam logic [CW-1:0]  HALF_M1  = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  BIT_M1   = CW'(CLK_PER_BIT - 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES_PER_RECORD - 1);
  localparam logic [GW-1:0]  GAP_M1   = GW'(GAP_LIMIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t         state_q, state_d;
  logic [1:0]     sync_q;
  logic           rx_s, rx_q;
  logic [CW-1:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [BCW-1:0] byte_cnt_q;
  logic [GW-1:0]  gap_cnt_q;
  logic [RW-1:0]  asm_q, asm_next;
  logic           start_det, byte_done, frame_bad;
  logic           last_byte, load, drop, gap_expire;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      rx_q   <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx};
      rx_q   <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // Bit timing: start bit checked at half a bit, then every full bit lands mid-bit.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + CW'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    start_det = 1'b0;
    byte_done = 1'b0;
    frame_bad = 1'b0;
    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (rx_q && !rx_s) begin
          start_det = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt_q == BIT_M1) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) state_d = STOP;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      STOP: begin
        if (clk_cnt_q == BIT_M1) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            byte_done = 1'b1;
            state_d   = IDLE;
          end else begin
            frame_bad = 1'b1;
            state_d   = BREAK;
          end
        end
      end
      BREAK: begin
        clk_cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign asm_next   = (asm_q << 8) | RW'(shift_q);
  assign last_byte  = byte_done && (byte_cnt_q == LAST_BYTE);
  assign load       = last_byte && (!record_valid || record_ready);
  assign drop       = last_byte && !load;
  assign gap_expire = (state_q == IDLE) && (byte_cnt_q != '0) && !start_det && (gap_cnt_q == GAP_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      asm_q      <= '0;
    end else begin
      if (frame_bad || gap_expire) byte_cnt_q <= '0;
      else if (byte_done)          byte_cnt_q <= last_byte ? '0 : byte_cnt_q + BCW'(1);

      if (byte_done) asm_q <= asm_next;

      // The gap timer only runs while a partial record is pending.
      if (start_det || byte_cnt_q == '0 || gap_expire) gap_cnt_q <= '0;
      else if (state_q == IDLE)                        gap_cnt_q <= gap_cnt_q + GW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      record       <= '0;
      record_valid <= 1'b0;
      framing_err  <= 1'b0;
      gap_err      <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (load) begin
        record       <= asm_next;
        record_valid <= 1'b1;
      end else if (record_ready) begin
        record_valid <= 1'b0;
      end
      framing_err <= frame_bad;
      gap_err     <= gap_expire;
      overrun     <= drop;
    end
  end

`ifdef TDC_RECORD_RX_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_count <= '0;
      err_count <= '0;
    end else begin
      if (load && rec_count != 16'hFFFF) rec_count <= rec_count + 16'd1;
      if ((frame_bad || gap_expire || drop) && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule
